// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the buffered UART transmitter.
// Parity support is selected in the top level by UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // 200 MHz board clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 1736;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter; pointers wrap modulo DEPTH.
// Storage is not reset, only the pointers and the count are.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = cnt_w(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_q];
    assign count    = cnt_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with back-to-back framing.
// Define UART_TX_PARITY_EN to insert a parity bit after the payload.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          parity_odd,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_done
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BW = cnt_w(DATA_BITS);

    tx_state_t            state_q;
    tx_state_t            state_d;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 baud_end;
    logic                 data_end;
    logic                 stop_end;
    logic                 par_bit;
    logic                 txd_d;
    logic                 done_d;

`ifdef UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit <= 1'b0;
        end else if (pop) begin
            par_bit <= ^fifo_data ^ parity_odd;
        end
    end
`else
    localparam tx_state_t AFTER_DATA = STOP;

    logic unused_parity;
    assign unused_parity = parity_odd;
    assign par_bit       = 1'b1;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s_valid && s_ready),
        .pop       (pop),
        .push_data (s_data),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign s_ready  = !fifo_full;
    assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign data_end = (bit_q == BW'(DATA_BITS - 1));
    assign stop_end = (bit_q == BW'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = START;
            end
            START: begin
                if (baud_end) state_d = DATA;
            end
            DATA: begin
                if (baud_end && data_end) state_d = AFTER_DATA;
            end
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
            STOP: begin
                if (baud_end && stop_end) begin
                    state_d = fifo_empty ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d  = 1'b1;
        done_d = (state_q == STOP) && baud_end && stop_end;
        pop    = (state_d == START) && (state_q != START);
        unique case (1'b1)
            state_q == START:  txd_d = 1'b0;
            state_q == DATA:   txd_d = shift_q[0];
            state_q == PARITY: txd_d = par_bit;
            default:           txd_d = 1'b1;
        endcase
    end

    // Counters restart on every state change so each bit is exactly one baud period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            if (state_d != state_q || state_q == IDLE) begin
                baud_q <= '0;
                bit_q  <= '0;
            end else if (baud_end) begin
                baud_q <= '0;
                bit_q  <= bit_q + 1'b1;
            end else begin
                baud_q <= baud_q + 1'b1;
            end
            if (pop) begin
                shift_q <= fifo_data;
            end else if (state_q == DATA && baud_end) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            TxD     <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            TxD     <= txd_d;
            busy    <= (state_q != IDLE);
            tx_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised bench for uart_tx_buffered against a per-cycle line model.
// Build with UART_TX_PARITY_EN to exercise the parity frames.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam int D   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int NB    = 1 + DB + PB + SB;
    localparam int FRAME = NB * CPB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          parity_odd = 1'b0;
    logic [DB-1:0] s_data = '0;
    logic          s_ready;
    logic          TxD;
    logic          busy;
    logic          tx_done;
    logic [2:0]    fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .parity_odd (parity_odd),
        .TxD        (TxD),
        .busy       (busy),
        .fifo_count (fifo_count),
        .tx_done    (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words waiting in the FIFO, and the line as a list of
    // per-cycle values {last_cycle_of_frame, txd}.
    bit [DB-1:0] mq[$];
    bit [1:0]    lq[$];
    logic        e_txd = 1'b1;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;
    int          e_count = 0;
    bit          model_on = 1'b0;

    function automatic void add_frame(input bit [DB-1:0] w, input bit odd);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(w[i]);
        if (PB != 0) bits.push_back(^w ^ odd);
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < CPB; c++)
                lq.push_back({(b == bits.size() - 1) && (c == CPB - 1), bits[b]});
    endfunction

    initial begin
        bit          do_pop;
        bit          do_push;
        bit [1:0]    cur;
        bit [DB-1:0] w;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                lq.delete();
                e_txd = 1'b1;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_count = 0;
            end else begin
                do_push = s_valid && (mq.size() != D);
                do_pop  = (mq.size() != 0) && (lq.size() <= 1);
                if (lq.size() != 0) begin
                    cur = lq.pop_front();
                    e_txd = cur[0];
                    e_busy = 1'b1;
                    e_done = cur[1];
                end else begin
                    e_txd = 1'b1;
                    e_busy = 1'b0;
                    e_done = 1'b0;
                end
                if (do_pop) begin
                    w = mq.pop_front();
                    add_frame(w, parity_odd);
                end
                if (do_push) mq.push_back(s_data);
                e_count = mq.size();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("txd", TxD, e_txd);
            check("busy", busy, e_busy);
            check("tx_done", tx_done, e_done);
            check("fifo_count", fifo_count, e_count);
            check("s_ready", s_ready, e_count != D);
        end
    end

    int done_cnt = 0;
    int busy_run = 0;
    int last_run = 0;
    int max_cnt = 0;
    int full_seen = 0;

    initial forever begin
        @(negedge clk);
        if (tx_done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (s_ready === 1'b0) full_seen++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_word(input logic [DB-1:0] w);
        int n = 0;
        s_valid = 1'b1;
        s_data = w;
        while (s_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("push_timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0 && fifo_count == 0) quiet++;
            else quiet = 0;
        end
        if (n >= 5000) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_fall();
        int n = 0;
        while (TxD !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("start_timeout", 0, 1);
    endtask

    task automatic capture_frame(output logic [10:0] fr);
        fr = '0;
        wait_fall();
        for (int b = 0; b < NB; b++) begin
            fr[b] = TxD;
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        logic [10:0] v;
        logic [10:0] fr;
        int d0;
        int dn;
        int lows;
        int n;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_on = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_txd", TxD, 1);
            check("idle_busy", busy, 0);
            check("idle_ready", s_ready, 1);
            check("idle_count", fifo_count, 0);
        end

        // 2: single 0xA5 frame, pinned cycle by cycle
`ifdef UART_TX_PARITY_EN
        v = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        v = {2'b00, 1'b1, 8'hA5, 1'b0};
`endif
        parity_odd = 1'b0;
        push_word(8'hA5);
        @(negedge clk);
        check("latency_early", TxD, 1);
        @(negedge clk);
        check("latency_start", TxD, 0);
        dn = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            check("a5_bit", TxD, v[i / CPB]);
            if (tx_done === 1'b1) dn++;
            if (i == FRAME - 1) check("a5_done_last", tx_done, 1);
        end
        check("a5_done_count", dn, 1);
        @(negedge clk);
        check("a5_end_txd", TxD, 1);
        check("a5_end_busy", busy, 0);

        // 3: five back-to-back words through a four-deep FIFO
        wait_idle();
        d0 = done_cnt;
        max_cnt = 0;
        full_seen = 0;
        for (int i = 1; i <= 5; i++) push_word(DB'(i));
        wait_idle();
        check("b2b_done", done_cnt - d0, 5);
        check("b2b_run", last_run, 5 * FRAME);
        check("b2b_max_count", max_cnt, 4);
        check("b2b_full_seen", full_seen > 0, 1);

`ifdef UART_TX_PARITY_EN
        // 4: parity bit for 0x07 under even and odd parity
        parity_odd = 1'b0;
        push_word(8'h07);
        capture_frame(fr);
        check("par_even_bit", fr[9], 1);
        check("par_even_data", fr[8:1], 8'h07);
        wait_idle();
        check("par_frame_len", last_run, 44);
        parity_odd = 1'b1;
        push_word(8'h07);
        capture_frame(fr);
        check("par_odd_bit", fr[9], 0);
        wait_idle();
        parity_odd = 1'b0;
`endif

        // 5: reset in the middle of data bit 3
        push_word(8'h3C);
        push_word(8'h55);
        wait_fall();
        repeat (CPB + 3 * CPB + 1) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_count", fifo_count, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_txd", TxD, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", s_ready, 1);
        check("rst_done", tx_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        check("post_rst_low", lows, 0);
        check("post_rst_done", done_cnt - d0, 0);

        // 6: push and pop on the same edge with two words held
        d0 = done_cnt;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        check("pp_count_before", fifo_count, 2);
        n = 0;
        while (lq.size() != 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("pp_timeout", 0, 1);
        check("pp_count_at", fifo_count, 2);
        s_valid = 1'b1;
        s_data = 8'h44;
        @(negedge clk);
        s_valid = 1'b0;
        check("pp_count_after", fifo_count, 2);
        check("pp_done", tx_done, 1);
        wait_idle();
        check("pp_frames", done_cnt - d0, 4);

        // random traffic: dense, then sparse
        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(0, 3) == 0);
            s_data = DB'($urandom);
            parity_odd = 1'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(0, 59) == 0);
            s_data = DB'($urandom);
            parity_odd = 1'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
